// File: rtl/pll_pkg.sv
// pll_pkg: state encoding shared by the divider channels (IDLE=0, DELAY=1, RUN=2)
package pll_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, RUN = 2'd2} state_t;
endpackage

// File: rtl/div_channel.sv
// div_channel: one programmable divider (shadowed div/high/phase, phase delay, registered out/stable/config_err)
module div_channel
  import pll_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] div,
  input  logic [W-1:0] high,
  input  logic [W-1:0] phase,
  output logic         out,
  output logic         stable,
  output logic         config_err
);
  state_t state, state_n;
  logic [W-1:0] div_s, high_s, phase_s, div_n, high_n, phase_n;
  logic [W-1:0] dcnt, pcnt, dcnt_n, pcnt_n, pcnt_inc;
  logic out_n, stable_n, go_idle, restart, wrap;
  assign div_n = load ? div : div_s;
  assign high_n = load ? high : high_s;
  assign phase_n = load ? phase : phase_s;
  assign go_idle = !en || div_n == '0;
  assign restart = load || state == IDLE;
  assign wrap = pcnt >= div_s - W'(1);
  assign pcnt_inc = wrap ? '0 : pcnt + W'(1);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = go_idle ? IDLE : restart ? DELAY : (state == RUN || dcnt == '0) ? RUN : DELAY;
  end
  always_comb begin
    dcnt_n = '0;
    pcnt_n = '0;
    out_n = 1'b0;
    stable_n = 1'b0;
    if (!go_idle && restart) dcnt_n = phase_n;
    else if (!go_idle && state == DELAY) begin
      dcnt_n = dcnt == '0 ? '0 : dcnt - W'(1);
      out_n = dcnt == '0 && high_s != '0;
    end else if (!go_idle && state == RUN) begin
      pcnt_n = pcnt_inc;
      out_n = pcnt_inc < high_s;
      stable_n = stable || wrap;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_s <= '0;
      high_s <= '0;
      phase_s <= '0;
      dcnt <= '0;
      pcnt <= '0;
      out <= 1'b0;
      stable <= 1'b0;
      config_err <= 1'b0;
    end else begin
      div_s <= div_n;
      high_s <= high_n;
      phase_s <= phase_n;
      dcnt <= dcnt_n;
      pcnt <= pcnt_n;
      out <= out_n;
      stable <= stable_n;
      config_err <= en && div_n == '0;
    end
  end
endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: CHANNELS independent div_channel instances; div/high/phase packed per channel, out/stable/config_err per channel
module clk_div_bank #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           en,
  input  logic                          load,
  input  logic [CHANNELS*CNT_WIDTH-1:0] div,
  input  logic [CHANNELS*CNT_WIDTH-1:0] high,
  input  logic [CHANNELS*CNT_WIDTH-1:0] phase,
  output logic [CHANNELS-1:0]           out,
  output logic [CHANNELS-1:0]           stable,
  output logic [CHANNELS-1:0]           config_err
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    div_channel #(.W(CNT_WIDTH)) u_ch (
      .clk(clk),
      .rst(rst),
      .en(en[i]),
      .load(load),
      .div(div[i*CNT_WIDTH +: CNT_WIDTH]),
      .high(high[i*CNT_WIDTH +: CNT_WIDTH]),
      .phase(phase[i*CNT_WIDTH +: CNT_WIDTH]),
      .out(out[i]),
      .stable(stable[i]),
      .config_err(config_err[i])
    );
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed vector table plus hand sequences for alignment, reload, en toggling and reset
module tb_clk_div_bank;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst, load;
  logic [N-1:0] en, out, stable, config_err;
  logic [N*W-1:0] div, high, phase;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int d;
    int h;
    int p;
    logic [15:0] pat;
    int st;
  } vec_t;
  vec_t tbl [7];
  clk_div_bank #(.CHANNELS(N), .CNT_WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .load(load),
    .div(div),
    .high(high),
    .phase(phase),
    .out(out),
    .stable(stable),
    .config_err(config_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int k, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got %b want %b", nm, k, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input int i, input int d, input int h, input int p);
    div[i*W +: W] = W'(d);
    high[i*W +: W] = W'(h);
    phase[i*W +: W] = W'(p);
  endtask
  function automatic logic mo(input int k, input int r, input int d, input int h);
    return k >= r && ((k - r) % d) < h;
  endfunction
  initial begin
    tbl[0] = '{4, 2, 0, 16'h6666, 5};
    tbl[1] = '{5, 7, 0, 16'hFFFE, 6};
    tbl[2] = '{5, 0, 2, 16'h0000, 8};
    tbl[3] = '{1, 1, 0, 16'hFFFE, 2};
    tbl[4] = '{3, 1, 1, 16'h4924, 5};
    tbl[5] = '{6, 3, 5, 16'h71C0, 12};
    tbl[6] = '{2, 1, 3, 16'h5550, 6};
    rst = 1'b1;
    en = '1;
    load = 1'b0;
    div = '0;
    high = '0;
    phase = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_out", k, out, '0);
      chk("rst_stable", k, stable, '0);
      chk("rst_err", k, config_err, '0);
    end
    for (int i = 0; i < N; i++) cfg(i, 4, 2, 0);
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("rst_prio_out", 0, out, '0);
    chk("rst_prio_err", 0, config_err, '0);
    rst = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("post_rst_out", k, out, '0);
      chk("post_rst_stable", k, stable, '0);
      chk("post_rst_err", k, config_err, '1);
    end
    foreach (tbl[v]) begin
      for (int i = 0; i < N; i++) cfg(i, tbl[v].d, tbl[v].h, tbl[v].p);
      load = 1'b1;
      for (int k = 0; k < 16; k++) begin
        tick();
        load = 1'b0;
        chk($sformatf("vec%0d_out", v), k, out, {N{tbl[v].pat[k]}});
        chk($sformatf("vec%0d_stable", v), k, stable, {N{k >= tbl[v].st}});
      end
      chk($sformatf("vec%0d_err", v), 15, config_err, '0);
    end
    cfg(0, 4, 2, 0);
    cfg(1, 6, 3, 5);
    cfg(2, 0, 1, 0);
    cfg(3, 3, 1, 0);
    en = 4'b0111;
    load = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      load = 1'b0;
      chk("align_out", k, out, {2'b00, mo(k, 6, 6, 3), mo(k, 1, 4, 2)});
      chk("align_stable", k, stable, {2'b00, k >= 12, k >= 5});
      chk("align_err", k, config_err, 4'b0100);
    end
    en = '1;
    for (int i = 0; i < N; i++) cfg(i, 3, 1, 0);
    load = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      load = 1'b0;
      chk("reload_out", k, out, {N{mo(k, 1, 3, 1)}});
      chk("reload_stable", k, stable, {N{k >= 4}});
    end
    for (int i = 0; i < N; i++) cfg(i, 4, 2, 2);
    load = 1'b1;
    for (int k = 0; k < 25; k++) begin
      logic e0, s0;
      en = (k >= 8 && k < 11) ? 4'b1110 : 4'b1111;
      tick();
      load = 1'b0;
      e0 = k < 8 ? mo(k, 3, 4, 2) : k < 11 ? 1'b0 : mo(k - 11, 3, 4, 2);
      s0 = k < 8 ? k >= 7 : k < 11 ? 1'b0 : k >= 18;
      chk("en_out", k, out, {{(N-1){mo(k, 3, 4, 2)}}, e0});
      chk("en_stable", k, stable, {{(N-1){k >= 7}}, s0});
    end
    rst = 1'b1;
    tick();
    chk("midrst_out", 0, out, '0);
    chk("midrst_stable", 0, stable, '0);
    chk("midrst_err", 0, config_err, '0);
    rst = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("idle_out", k, out, '0);
      chk("idle_stable", k, stable, '0);
      chk("idle_err", k, config_err, '1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
